// File: rtl/inst_fetch_queue_pkg.sv
// Opcode constants, FSM encoding, FIFO entry layout and the immediate decoders shared with the decoder.
// Pure definitions: no latency, no backpressure.
package inst_fetch_queue_pkg;

  localparam int QUEUE_DEPTH_BIT_DEF = 2;

  localparam logic [6:0] CodeJal  = 7'b1101111;
  localparam logic [6:0] CodeBr   = 7'b1100011;
  localparam logic [6:0] CodeJalr = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Memory-controller and decoder-facing signals of the fetch queue.
// master = fetch unit, slave = memory controller plus decoder.
interface inst_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        dec_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output mem_req, mem_addr, out_valid, out_pc, out_inst,
    input  mem_done, mem_data, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_pc, out_inst,
    output mem_done, mem_data, dec_ready
  );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Instruction FIFO with push, pop and clear; head entry readable combinationally (0-cycle read).
// Clear beats push/pop; i_en low freezes all state; pop on empty is ignored.
module inst_fetch_queue_fifo #(
  parameter int DEPTH_BIT = 2,
  parameter int WIDTH     = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_vld,
  output logic             o_full
);
  localparam int                 DEPTH    = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_BIT-1:0] r_head;
  logic [DEPTH_BIT-1:0] r_tail;
  logic [DEPTH_BIT:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_vld      = (r_count != '0);
  assign o_full     = (r_count == FULL_CNT);
  assign o_head_dat = r_mem[r_head];
  assign w_push     = i_en && !i_clr && i_push;
  assign w_pop      = i_en && !i_clr && i_pop && o_vld;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH_BIT bits.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en && i_clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch unit: one outstanding word fetch, static next-PC prediction, FIFO to decoder (push->valid 1 cycle).
// Issue stalls when the FIFO is full or fetch is halted on JALR; rdy_in low freezes everything.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          QUEUE_DEPTH_BIT = QUEUE_DEPTH_BIT_DEF,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  inst_fetch_queue_if.master bus
);
  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_mem_addr;
  logic         r_halted;
  logic [31:0]  w_pc_pred;
  logic         w_halt_pred;
  logic         w_issue;
  logic         w_push;
  logic         w_full;
  logic         w_vld;
  fetch_entry_t w_push_dat;
  fetch_entry_t w_head_dat;
  logic [63:0]  w_head_raw;

  always_comb begin
    w_pc_pred   = r_pc + 32'd4;
    w_halt_pred = 1'b0;
    case (bus.mem_data[6:0])
      CodeJal:  w_pc_pred = r_pc + imm_j(bus.mem_data);
      CodeBr:   w_pc_pred = r_pc + imm_b(bus.mem_data);
      CodeJalr: begin
        w_pc_pred   = r_pc;
        w_halt_pred = 1'b1;
      end
      default:  ;
    endcase
  end

  // The request cannot be withdrawn once issued, so a redirect while BUSY
  // parks in DROP until the stale response arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_halted && !w_full && !redirect_valid) begin
          w_state_nxt = BUSY;
          w_issue     = 1'b1;
        end
      end
      BUSY: begin
        if (bus.mem_done) begin
          w_state_nxt = IDLE;
          w_push      = !redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (bus.mem_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc       <= RESET_PC;
      r_halted   <= 1'b0;
      r_mem_addr <= 32'h0;
    end else if (rdy_in) begin
      if (w_issue) begin
        r_mem_addr <= r_pc;
      end
      if (redirect_valid) begin
        r_pc     <= redirect_pc;
        r_halted <= 1'b0;
      end else if (w_push) begin
        r_pc     <= w_pc_pred;
        r_halted <= w_halt_pred;
      end
    end
  end

  assign w_push_dat.pc   = r_pc;
  assign w_push_dat.inst = bus.mem_data;

  inst_fetch_queue_fifo #(
    .DEPTH_BIT (QUEUE_DEPTH_BIT),
    .WIDTH     (64)
  ) u_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_en       (rdy_in),
    .i_clr      (redirect_valid),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (bus.dec_ready),
    .o_head_dat (w_head_raw),
    .o_vld      (w_vld),
    .o_full     (w_full)
  );

  assign w_head_dat    = fetch_entry_t'(w_head_raw);
  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = w_vld;
  assign bus.out_pc    = w_head_dat.pc;
  assign bus.out_inst  = w_head_dat.inst;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed predecode table, multi-cycle corner sequences,
// then random traffic against a queue-based reference model.
module tb_inst_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(
    .QUEUE_DEPTH_BIT (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic [31:0] nxt;
  } vec_t;
  vec_t vecs[8];

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_stale;
  bit          m_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_req"}, {31'b0, bus.mem_req}, 32'd1);
  endtask

  task automatic respond(input logic [31:0] data);
    bus.mem_done = 1'b1;
    bus.mem_data = data;
    step();
    bus.mem_done = 1'b0;
    bus.mem_data = 32'h0;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    bus.mem_done   = bus.mem_req;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    bus.mem_done   = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic idle_for(input string nm, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      step();
      seen |= bus.mem_req;
    end
    chk(nm, {31'b0, seen}, 32'd0);
  endtask

  // Branch/jump target from the encoding rules, by plain arithmetic.
  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] i);
    logic [31:0] off;
    case (i[6:0])
      7'b1101111: begin
        off = (32'(i[30:21]) << 1) + (32'(i[20]) << 11) + (32'(i[19:12]) << 12);
        if (i[31]) off = off - 32'h0010_0000;
      end
      7'b1100011: begin
        off = (32'(i[11:8]) << 1) + (32'(i[30:25]) << 5) + (32'(i[7]) << 11);
        if (i[31]) off = off - 32'h0000_1000;
      end
      default: off = 32'd4;
    endcase
    return pc + off;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    case ($urandom % 9)
      0, 1, 2: return 32'h0000_0013;
      3:       return {r[31:7], 7'b0110011};
      4, 5:    return {r[31:7], 7'b1101111};
      6, 7:    return {r[31:7], 7'b1100011};
      default: return {r[31:7], 7'b1100111};
    endcase
  endfunction

  task automatic model_step();
    bit can_issue;
    if (!rdy_in) return;
    can_issue = !m_pend && !m_halt && (m_q.size() < 4) && !redirect_valid;
    if (redirect_valid) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_halt = 0;
      if (m_pend && bus.mem_done) begin
        m_pend  = 0;
        m_stale = 0;
      end else if (m_pend) begin
        m_stale = 1;
      end
    end else begin
      if (bus.dec_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_pend && bus.mem_done) begin
        if (!m_stale) begin
          m_q.push_back({m_pc, bus.mem_data});
          if (bus.mem_data[6:0] == 7'b1100111) m_halt = 1;
          else m_pc = ref_target(m_pc, bus.mem_data);
        end
        m_pend  = 0;
        m_stale = 0;
      end
    end
    if (can_issue) begin
      m_pend = 1;
      m_addr = m_pc;
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0080_006F, 1'b0, 32'h0000_0018};
    vecs[1] = '{32'h0000_0018, 32'hFE00_0EE3, 1'b0, 32'h0000_0014};
    vecs[2] = '{32'h0000_0030, 32'h0000_0463, 1'b0, 32'h0000_0038};
    vecs[3] = '{32'h0000_0100, 32'h8000_006F, 1'b0, 32'hFFF0_0100};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0020, 32'h0000_8067, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'h0000_0040, 32'h0000_0013, 1'b0, 32'h0000_0044};
    vecs[7] = '{32'h0000_0050, 32'h0000_0033, 1'b0, 32'h0000_0054};

    bus.mem_done  = 1'b0;
    bus.mem_data  = 32'h0;
    bus.dec_ready = 1'b0;
    rst_in = 1'b0;
    repeat (2) step();
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_in = 1'b1;

    // Two sequential addi fetches from the reset PC
    wait_req("t1_a");
    chk("t1_addr0", bus.mem_addr, 32'h0);
    respond(32'h0000_0013);
    chk("t1_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("t1_pc", bus.out_pc, 32'h0);
    chk("t1_inst", bus.out_inst, 32'h13);
    wait_req("t1_b");
    chk("t1_addr4", bus.mem_addr, 32'h4);

    for (int i = 0; i < 8; i++) begin
      flush_to(vecs[i].pc);
      chk($sformatf("v%0d_flushed", i), {31'b0, bus.out_valid}, 32'd0);
      wait_req($sformatf("v%0d_a", i));
      chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].pc);
      respond(vecs[i].inst);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].pc);
      chk($sformatf("v%0d_inst", i), bus.out_inst, vecs[i].inst);
      if (vecs[i].halt) begin
        idle_for($sformatf("v%0d_halted", i), 5);
      end else begin
        wait_req($sformatf("v%0d_b", i));
        chk($sformatf("v%0d_next", i), bus.mem_addr, vecs[i].nxt);
      end
    end

    // Fill to depth, stall, pop frees one slot, push+pop keeps count
    flush_to(32'h200);
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("t4_fill%0d", k));
      chk($sformatf("t4_addr%0d", k), bus.mem_addr, 32'h200 + 32'(4 * k));
      respond(32'h0000_0013);
    end
    idle_for("t4_full_stall", 5);
    chk("t4_head", bus.out_pc, 32'h200);
    bus.dec_ready = 1'b1;
    step();
    bus.dec_ready = 1'b0;
    chk("t4_pop_head", bus.out_pc, 32'h204);
    wait_req("t4_refill");
    chk("t4_refill_addr", bus.mem_addr, 32'h210);
    bus.dec_ready = 1'b1;
    respond(32'h0000_0013);
    bus.dec_ready = 1'b0;
    chk("t4_pushpop_head", bus.out_pc, 32'h208);
    wait_req("t4_after_pushpop");
    chk("t4_after_pushpop_addr", bus.mem_addr, 32'h214);
    respond(32'h0000_0013);
    idle_for("t4_full_again", 4);

    // Redirect while BUSY; stale response arrives two cycles later
    flush_to(32'h80);
    wait_req("t5_a");
    chk("t5_addr", bus.mem_addr, 32'h80);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t5_req_held", {31'b0, bus.mem_req}, 32'd1);
    step();
    respond(32'h0000_0013);
    chk("t5_dropped", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_req_low", {31'b0, bus.mem_req}, 32'd0);
    wait_req("t5_b");
    chk("t5_next_addr", bus.mem_addr, 32'h100);

    // Redirect coinciding with mem_done
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    respond(32'h0000_0013);
    redirect_valid = 1'b0;
    chk("t6_no_push", {31'b0, bus.out_valid}, 32'd0);
    chk("t6_req_low", {31'b0, bus.mem_req}, 32'd0);
    wait_req("t6_a");
    chk("t6_addr", bus.mem_addr, 32'h400);

    // Asynchronous reset mid-cycle while BUSY with a non-empty FIFO
    respond(32'h0000_0013);
    wait_req("t6_b");
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_arst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("t6_arst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t6_arst_addr", bus.mem_addr, 32'h0);
    step();
    rst_in = 1'b1;
    wait_req("t6_c");
    chk("t6_reset_pc", bus.mem_addr, 32'h0);

    // Random traffic against the reference model
    rst_in = 1'b0;
    redirect_valid = 1'b0;
    bus.mem_done = 1'b0;
    bus.dec_ready = 1'b0;
    step();
    rst_in = 1'b1;
    m_q.delete();
    m_pc = 32'h0;
    m_addr = 32'h0;
    m_pend = 0;
    m_stale = 0;
    m_halt = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in         = ($urandom % 8) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc    = $urandom;
      bus.dec_ready  = $urandom % 2;
      bus.mem_done   = m_pend && (($urandom % 3) == 0);
      bus.mem_data   = rand_inst();
      model_step();
      step();
      chk("rnd_mem_req", {31'b0, bus.mem_req}, {31'b0, m_pend});
      chk("rnd_mem_addr", bus.mem_addr, m_addr);
      chk("rnd_out_valid", {31'b0, bus.out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("rnd_out_pc", bus.out_pc, m_q[0][63:32]);
        chk("rnd_out_inst", bus.out_inst, m_q[0][31:0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
